// File: rtl/load_store_sched.sv
// Round-robin scheduler sharing one bounded volume counter between NREQ requesters.
// Each grant fills or drains the volume one unit per cycle until done or full/empty.
module load_store_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CAP   = 12500,
  parameter int unsigned CBITS = 14,
  parameter int unsigned AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    dir,
  input  logic [NREQ*AW-1:0] amt,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [CBITS-1:0]   vol,
  output logic               full,
  output logic               empty
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] VMAX = CBITS'(CAP);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [IW-1:0]     r_ptr, w_ptr_nxt;
  logic              r_dir, w_dir_nxt;
  logic [AW-1:0]     r_cnt, w_cnt_nxt;
  logic [CBITS-1:0]  r_vol, w_vol_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_short, w_short_nxt;
  logic              r_full, r_empty;

  logic [IW:0]       w_pick;
  logic              w_found;
  logic [IW-1:0]     w_sel;
  logic [AW-1:0]     w_amt_sel;
  logic              w_at_limit;

  // First requester at or after ptr, wrapping; MSB flags that one was found.
  function automatic logic [IW:0] f_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0]  res;
    logic [31:0]  k;
    res = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(p) + i) % NREQ;
      if (!res[IW] && r[k[IW-1:0]]) res = {1'b1, k[IW-1:0]};
    end
    return res;
  endfunction

  assign w_pick     = f_pick(req, r_ptr);
  assign w_found    = w_pick[IW];
  assign w_sel      = w_pick[IW-1:0];
  assign w_amt_sel  = amt[32'(w_sel)*AW +: AW];
  assign w_at_limit = r_dir ? (r_vol == VMAX) : (r_vol == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_vol_nxt   = r_vol;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_short_nxt = r_short;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_idx_nxt   = w_sel;
          w_dir_nxt   = dir[w_sel];
          w_cnt_nxt   = w_amt_sel;
          w_gnt_nxt   = NREQ'(1) << w_sel;
          w_busy_nxt  = 1'b1;
          w_short_nxt = 1'b0;
          if (w_amt_sel == '0) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_XFER;
          end
        end
      end
      S_XFER: begin
        // Limit is judged on the pre-edge volume, so truncation lands one edge late.
        if (w_at_limit) begin
          w_short_nxt = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_vol_nxt = r_dir ? (r_vol + CBITS'(1)) : (r_vol - CBITS'(1));
          w_cnt_nxt = r_cnt - AW'(1);
          if (r_cnt == AW'(1)) begin
            w_short_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_short_nxt = 1'b0;
        w_ptr_nxt   = (r_idx == IW'(NREQ - 1)) ? '0 : (r_idx + IW'(1));
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers; full/empty track the next volume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_ptr   <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_vol   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_short <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vol   <= w_vol_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_short <= w_short_nxt;
      r_full  <= (w_vol_nxt == VMAX);
      r_empty <= (w_vol_nxt == '0);
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign done  = r_done;
  assign short = r_short;
  assign vol   = r_vol;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: tb/tb_load_store_sched.sv
// Bench for load_store_sched: transaction-level model expands each grant into
// an expected per-cycle timeline; directed scenarios plus randomized traffic.
module tb_load_store_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned CAP   = 20;
  localparam int unsigned CBITS = 14;
  localparam int unsigned AW    = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    dir;
  logic [NREQ*AW-1:0] amt;
  logic [NREQ-1:0]    gnt;
  logic               busy, done, short;
  logic [CBITS-1:0]   vol;
  logic               full, empty;

  load_store_sched #(.NREQ(NREQ), .CAP(CAP), .CBITS(CBITS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .amt(amt),
    .gnt(gnt), .busy(busy), .done(done), .short(short),
    .vol(vol), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            done;
    logic            shrt;
    int              vol;
  } snap_t;

  snap_t q[$];
  snap_t exp_s;
  int    m_vol, m_ptr;
  int    n_checks, n_errors;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // Expand one granted transaction into the expected output of every following cycle.
  task automatic start_txn(input int i);
    int              a, room, units, fin;
    bit              d, trunc;
    logic [NREQ-1:0] g;
    a     = int'(amt[i*AW +: AW]);
    d     = dir[i];
    room  = d ? (int'(CAP) - m_vol) : m_vol;
    units = (a < room) ? a : room;
    trunc = (a > room);
    g     = NREQ'(1) << i;
    exp_s = '{g, 1'b1, (a == 0), 1'b0, m_vol};
    for (int j = 1; j <= units; j++)
      q.push_back('{g, 1'b1, (!trunc && j == units), 1'b0, d ? m_vol + j : m_vol - j});
    fin = d ? m_vol + units : m_vol - units;
    if (trunc) q.push_back('{g, 1'b1, 1'b1, 1'b1, fin});
    q.push_back('{'0, 1'b0, 1'b0, 1'b0, fin});
    m_vol = fin;
    m_ptr = (i + 1) % NREQ;
  endtask

  task automatic model_reset();
    q.delete();
    m_vol = 0;
    m_ptr = 0;
    exp_s = '{'0, 1'b0, 1'b0, 1'b0, 0};
  endtask

  task automatic model_step();
    int i;
    if (!rst) begin
      model_reset();
    end else if (q.size() > 0) begin
      exp_s = q.pop_front();
    end else begin
      exp_s = '{'0, 1'b0, 1'b0, 1'b0, m_vol};
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (req[i]) begin
          start_txn(i);
          break;
        end
      end
    end
  endtask

  task automatic compare();
    check("gnt",   32'(gnt),   32'(exp_s.gnt));
    check("busy",  32'(busy),  32'(exp_s.busy));
    check("done",  32'(done),  32'(exp_s.done));
    check("short", 32'(short), 32'(exp_s.shrt));
    check("vol",   32'(vol),   32'(exp_s.vol));
    check("full",  32'(full),  (exp_s.vol == int'(CAP)) ? 32'd1 : 32'd0);
    check("empty", 32'(empty), (exp_s.vol == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_amt(input int i, input int v);
    amt[i*AW +: AW] = AW'(v);
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_gnt"},   32'(gnt),   32'd0);
    check({tag, "_vol"},   32'(vol),   32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; req = '0; dir = '0; amt = '0;
    model_reset();

    // Reset values, then idle hold after release
    repeat (3) tick();
    check("rst_vol",   32'(vol),   32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    rst = 1'b1;
    repeat (3) tick();

    // Single store of 5; later dir/amt/req changes must be ignored
    req = 4'b0001; dir = 4'b0001; set_amt(0, 5);
    tick();
    check("st_gnt_e0", 32'(gnt), 32'd1);
    req = '0; dir = '0; set_amt(0, 99);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 5) begin
        check("st_vol_e5",   32'(vol),   32'd5);
        check("st_done_e5",  32'(done),  32'd1);
        check("st_short_e5", 32'(short), 32'd0);
      end
      if (t == 6) begin
        check("st_gnt_e6",  32'(gnt),  32'd0);
        check("st_busy_e6", 32'(busy), 32'd0);
      end
    end

    // Bring volume to 17, then saturating store of 10
    req = 4'b0010; dir = 4'b0010; set_amt(1, 12);
    tick();
    req = '0;
    repeat (13) tick();
    check("sat_pre_vol", 32'(vol), 32'd17);
    req = 4'b0100; dir = 4'b0100; set_amt(2, 10);
    tick();
    req = '0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 3) begin
        check("sat_vol_e3",  32'(vol),  32'd20);
        check("sat_done_e3", 32'(done), 32'd0);
      end
      if (t == 4) begin
        check("sat_done_e4",  32'(done),  32'd1);
        check("sat_short_e4", 32'(short), 32'd1);
        check("sat_full_e4",  32'(full),  32'd1);
      end
    end

    // Drain to 0, then load at empty from requester 2
    req = 4'b1000; dir = 4'b0000; set_amt(3, 20);
    tick();
    req = '0;
    repeat (21) tick();
    req = 4'b0100; dir = 4'b0000; set_amt(2, 4);
    tick();
    check("ld_gnt_e0", 32'(gnt), 32'd4);
    req = '0;
    tick();
    check("ld_done_e1",  32'(done),  32'd1);
    check("ld_short_e1", 32'(short), 32'd1);
    check("ld_empty_e1", 32'(empty), 32'd1);
    tick();

    // Zero-amount request completes at the granting edge
    req = 4'b0001; dir = 4'b0001; set_amt(0, 0);
    tick();
    check("z_done_e0",  32'(done),  32'd1);
    check("z_short_e0", 32'(short), 32'd0);
    check("z_vol_e0",   32'(vol),   32'd0);
    req = '0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a store of 8
    req = 4'b0001; dir = 4'b0001; set_amt(0, 8);
    tick();
    req = '0;
    repeat (3) tick();
    check("mid_vol_e3", 32'(vol), 32'd3);
    async_reset_check("mid");
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Round-robin with all requesters storing one unit
    req = 4'b1111; dir = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_amt(i, 1);
    for (int t = 0; t < 15; t++) begin
      tick();
      if (t % 3 == 0) begin
        check("rr_gnt", 32'(gnt), 32'(1 << ((t / 3) % NREQ)));
        check("rr_vol", 32'(vol), 32'(t / 3));
      end
      if (t % 3 == 1) check("rr_done", 32'(done), 32'd1);
    end
    req = '0;
    repeat (3) tick();

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      else if ($urandom_range(0, 3) == 0) req = '0;
      dir = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) set_amt(i, int'($urandom_range(0, 25)));
      if ($urandom_range(0, 799) == 0) begin
        async_reset_check("rnd_rst");
        tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
